fsm: RTL and testbench
======================

# fsm

Single-clock vending-machine controller. It accumulates inserted coins and accepts a drink selection: tea 10, coke 15, coffee 20, milk 25. When credit covers the price it dispenses and returns change; on cancel it refunds all credit. It sits between the coin/selection front panel and the dispenser/change-return actuators. All outputs are registered.

## Interface
Parameters:
- PRICE_TEA, 8'd10, tea code and price
- PRICE_COKE, 8'd15, coke code and price
- PRICE_COFFEE, 8'd20, coffee code and price
- PRICE_MILK, 8'd25, milk code and price

Ports (positional order as listed):
- clk  input  1  single system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- coin  input  8  value of the coin presented this cycle; legal values are 1, 5, 10, 50
- drink_choose  input  8  drink code, equal to its price (10/15/20/25)
- cancel  input  1  level; request refund of all credit
- inputCoin  input  1  level; coin is valid this cycle
- hasChosen  input  1  level; drink_choose is valid this cycle
- state  output  2  current state: 0 IDLE, 1 COIN, 2 DISPENSE
- total  output  8  accumulated credit
- dispense  output  1  one-cycle pulse when a drink is released
- drink_out  output  8  code of the dispensed drink; held until the next dispense
- change  output  8  amount returned; valid while change_valid=1
- change_valid  output  1  one-cycle pulse on dispense or on refund

## Operation
- Reset (reset=0, asynchronous) sets: state=IDLE, total=0, dispense=0, drink_out=0, change=0, change_valid=0.
- Valid coin: inputCoin=1 and coin is 1, 5, 10 or 50. Any other value is ignored and adds nothing.
- Valid selection: hasChosen=1 and drink_choose equals one of the four codes. Other codes are ignored.
- Credit arithmetic: total <= min(total+coin, 255), saturating. change = total − price, computed in 8-bit unsigned. It cannot underflow, because dispensing requires total ≥ price.
- Per-edge priority, evaluated in IDLE/COIN: cancel > affordable selection > coin.
- IDLE:
  - cancel → no effect.
  - valid coin → total=coin, go to COIN.
  - a selection with total=0 → ignored.
- COIN:
  - cancel=1 → change=total, change_valid=1, total=0, go to IDLE. A coin presented the same cycle is rejected.
  - valid selection with total ≥ price → dispense=1, drink_out=drink_choose, change=total−price, change_valid=1, total=0, go to DISPENSE. A coin presented the same cycle is rejected.
  - valid selection with total < price → selection ignored. Any valid coin is still added. Selection is re-evaluated every cycle while hasChosen stays high, so it completes automatically once credit suffices.
  - otherwise, valid coin → accumulate.
- DISPENSE:
  - all inputs are ignored; go to IDLE on the next edge.
- Pulse handling: dispense and change_valid return to 0 on the cycle after they are raised.
- A held cancel or held hasChosen after completion has no further effect, because total=0 in IDLE.

## Timing
- Coin latency: a coin sampled at edge N is reflected in total after edge N. One coin is accepted per cycle while inputCoin=1, so holding inputCoin high for k cycles with coin=10 adds 10·k.
- Purchase latency: a selection sampled at edge N raises dispense and change_valid after edge N, for exactly one cycle. state is DISPENSE during that cycle and IDLE after edge N+1.
- Refund latency: cancel sampled at edge N raises change_valid after edge N, for one cycle. state is IDLE immediately.
- Minimum spacing between two purchases: 2 cycles (the DISPENSE cycle, then a coin in IDLE).
- Reset mid-transaction: credit is lost with no refund pulse. Outputs clear immediately, independent of clk.

## Test plan
- Reset, then coins 10,1,10,10,10,10 on consecutive cycles (total 51), then coffee with hasChosen=1 → dispense pulse, drink_out=20, change=31, total=0, state DISPENSE→IDLE.
- Coins 5,10, then cancel=1 for 3 cycles → one change_valid pulse with change=15, total=0, state IDLE; no further pulses.
- Coins totalling 11 with hasChosen=1 and milk selected, then one coin per cycle (1,1,…,10) → no dispense while total<25; dispense occurs on the first edge where total ≥ 25, with change equal to the excess.
- Back-to-back purchases: credit 20 then coke → change 5; credit 10 then tea → change 0; coin 50 then coffee → change 30. Each dispense separated by a DISPENSE cycle.
- Illegal coin 7 and illegal drink code 12 → total unchanged, no dispense. Coins 50×6 → total saturates at 255.
- Reset asserted while total=25 in COIN → all outputs 0 immediately and no change_valid pulse.

Source files
------------

// File: rtl/fsm.sv
// Vending-machine controller: accumulates coins, dispenses a selected drink with change,
// and refunds all credit on cancel. All outputs are registered.
module fsm #(
  parameter logic [7:0] PRICE_TEA    = 8'd10,
  parameter logic [7:0] PRICE_COKE   = 8'd15,
  parameter logic [7:0] PRICE_COFFEE = 8'd20,
  parameter logic [7:0] PRICE_MILK   = 8'd25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] coin,
  input  logic [7:0] drink_choose,
  input  logic       cancel,
  input  logic       inputCoin,
  input  logic       hasChosen,
  output logic [1:0] state,
  output logic [7:0] total,
  output logic       dispense,
  output logic [7:0] drink_out,
  output logic [7:0] change,
  output logic       change_valid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COIN     = 2'd1,
    DISPENSE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] total_q, total_d;
  logic       dispense_q, dispense_d;
  logic [7:0] drinkOut_q, drinkOut_d;
  logic [7:0] change_q, change_d;
  logic       changeValid_q, changeValid_d;

  logic       coinValid;
  logic       selValid;
  logic       affordable;
  logic [8:0] coinSum;
  logic [7:0] coinSat;

  assign coinValid  = inputCoin && ((coin == 8'd1) || (coin == 8'd5) ||
                                    (coin == 8'd10) || (coin == 8'd50));
  assign selValid   = hasChosen && ((drink_choose == PRICE_TEA) || (drink_choose == PRICE_COKE) ||
                                    (drink_choose == PRICE_COFFEE) || (drink_choose == PRICE_MILK));
  // Drink code doubles as its price, so affordability compares credit to the code.
  assign affordable = selValid && (total_q >= drink_choose);
  assign coinSum    = {1'b0, total_q} + {1'b0, coin};
  assign coinSat    = coinSum[8] ? 8'hFF : coinSum[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      total_q       <= 8'd0;
      dispense_q    <= 1'b0;
      drinkOut_q    <= 8'd0;
      change_q      <= 8'd0;
      changeValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_q       <= total_d;
      dispense_q    <= dispense_d;
      drinkOut_q    <= drinkOut_d;
      change_q      <= change_d;
      changeValid_q <= changeValid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    total_d       = total_q;
    dispense_d    = 1'b0;
    drinkOut_d    = drinkOut_q;
    change_d      = change_q;
    changeValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Credit is always zero here, so cancel and selections have nothing to act on.
        if (coinValid) begin
          total_d = coin;
          state_d = COIN;
        end
      end
      COIN: begin
        if (cancel) begin
          change_d      = total_q;
          changeValid_d = 1'b1;
          total_d       = 8'd0;
          state_d       = IDLE;
        end else if (affordable) begin
          dispense_d    = 1'b1;
          drinkOut_d    = drink_choose;
          change_d      = total_q - drink_choose;
          changeValid_d = 1'b1;
          total_d       = 8'd0;
          state_d       = DISPENSE;
        end else if (coinValid) begin
          total_d = coinSat;
        end
      end
      DISPENSE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign state        = state_q;
  assign total        = total_q;
  assign dispense     = dispense_q;
  assign drink_out    = drinkOut_q;
  assign change       = change_q;
  assign change_valid = changeValid_q;

endmodule

// File: tb/tb_fsm.sv
// Directed testbench for the vending-machine controller: expected outputs are queued
// when each step is driven and compared after the clock edge that produces them.
module tb_fsm;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SC = 2'd1;
  localparam logic [1:0] SD = 2'd2;
  localparam logic [7:0] Z  = 8'd0;

  logic       clk;
  logic       resetN;
  logic [7:0] coin;
  logic [7:0] drinkChoose;
  logic       cancel;
  logic       inputCoin;
  logic       hasChosen;
  logic [1:0] state;
  logic [7:0] total;
  logic       dispense;
  logic [7:0] drinkOut;
  logic [7:0] change;
  logic       changeValid;

  typedef struct {
    logic [1:0] st;
    logic [7:0] tot;
    logic       disp;
    logic [7:0] drk;
    logic       cv;
    logic [7:0] chg;
  } expect_t;

  expect_t scoreboard[$];
  int      errors;
  int      checks;
  int      stepNo;

  fsm dut (
    .clk         (clk),
    .reset       (resetN),
    .coin        (coin),
    .drink_choose(drinkChoose),
    .cancel      (cancel),
    .inputCoin   (inputCoin),
    .hasChosen   (hasChosen),
    .state       (state),
    .total       (total),
    .dispense    (dispense),
    .drink_out   (drinkOut),
    .change      (change),
    .change_valid(changeValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s step %0d: observed=%0d expected=%0d", tag, stepNo, obs, exp);
    end
  endtask

  task automatic pushExpect(input logic [1:0] es, input logic [7:0] et, input logic ed,
                            input logic [7:0] edr, input logic ecv, input logic [7:0] ech);
    expect_t e;
    e.st = es; e.tot = et; e.disp = ed; e.drk = edr; e.cv = ecv; e.chg = ech;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    expect_t e;
    checks++;
    assert (scoreboard.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard step %0d: observed=empty expected=entry", stepNo);
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      checkField("state", {6'b0, state}, {6'b0, e.st});
      checkField("total", total, e.tot);
      checkField("dispense", {7'b0, dispense}, {7'b0, e.disp});
      checkField("drink_out", drinkOut, e.drk);
      checkField("change_valid", {7'b0, changeValid}, {7'b0, e.cv});
      if (e.cv) checkField("change", change, e.chg);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] d, input logic can,
                               input logic ic, input logic hc,
                               input logic [1:0] es, input logic [7:0] et, input logic ed,
                               input logic [7:0] edr, input logic ecv, input logic [7:0] ech);
    @(negedge clk);
    coin = c; drinkChoose = d; cancel = can; inputCoin = ic; hasChosen = hc;
    pushExpect(es, et, ed, edr, ecv, ech);
    @(posedge clk);
    #1;
    stepNo++;
    checkOutput();
  endtask

  initial begin
    errors = 0; checks = 0; stepNo = 0;
    coin = Z; drinkChoose = Z; cancel = 1'b0; inputCoin = 1'b0; hasChosen = 1'b0;
    resetN = 1'b0;
    #12;
    pushExpect(SI, Z, 1'b0, Z, 1'b0, Z);
    checkOutput();
    resetN = 1'b1;

    // Coins 10,1,10,10,10,10 then coffee: change 31.
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, Z, 1'b0, Z);
    applyStimulus(8'd1,  Z, 1'b0, 1'b1, 1'b0, SC, 8'd11, 1'b0, Z, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd21, 1'b0, Z, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd31, 1'b0, Z, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd41, 1'b0, Z, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd51, 1'b0, Z, 1'b0, Z);
    applyStimulus(Z, 8'd20, 1'b0, 1'b0, 1'b1, SD, Z, 1'b1, 8'd20, 1'b1, 8'd31);
    applyStimulus(Z, Z, 1'b0, 1'b0, 1'b0, SI, Z, 1'b0, 8'd20, 1'b0, Z);

    // Coins 5,10 then cancel held for three cycles: a single refund of 15.
    applyStimulus(8'd5,  Z, 1'b0, 1'b1, 1'b0, SC, 8'd5,  1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd15, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b1, 1'b1, 1'b0, SI, Z, 1'b0, 8'd20, 1'b1, 8'd15);
    applyStimulus(Z, Z, 1'b1, 1'b0, 1'b0, SI, Z, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(Z, Z, 1'b1, 1'b0, 1'b0, SI, Z, 1'b0, 8'd20, 1'b0, Z);

    // Milk held selected while credit grows; purchase fires once credit reaches 33.
    applyStimulus(8'd10, 8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd10, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd1,  8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd11, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd1,  8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd12, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd1,  8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd13, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, 8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd23, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, 8'd25, 1'b0, 1'b1, 1'b1, SC, 8'd33, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd1,  8'd25, 1'b0, 1'b1, 1'b1, SD, Z, 1'b1, 8'd25, 1'b1, 8'd8);
    applyStimulus(Z, 8'd25, 1'b0, 1'b0, 1'b1, SI, Z, 1'b0, 8'd25, 1'b0, Z);
    applyStimulus(Z, 8'd25, 1'b0, 1'b0, 1'b1, SI, Z, 1'b0, 8'd25, 1'b0, Z);

    // Back-to-back purchases: coke change 5, tea change 0, coffee change 30.
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, 8'd25, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd20, 1'b0, 8'd25, 1'b0, Z);
    applyStimulus(Z, 8'd15, 1'b0, 1'b0, 1'b1, SD, Z, 1'b1, 8'd15, 1'b1, 8'd5);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SI, Z, 1'b0, 8'd15, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, 8'd15, 1'b0, Z);
    applyStimulus(Z, 8'd10, 1'b0, 1'b0, 1'b1, SD, Z, 1'b1, 8'd10, 1'b1, 8'd0);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SI, Z, 1'b0, 8'd10, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd50, 1'b0, 8'd10, 1'b0, Z);
    applyStimulus(Z, 8'd20, 1'b0, 1'b0, 1'b1, SD, Z, 1'b1, 8'd20, 1'b1, 8'd30);
    applyStimulus(Z, Z, 1'b0, 1'b0, 1'b0, SI, Z, 1'b0, 8'd20, 1'b0, Z);

    // Illegal coin and drink code, then saturation at 255 and a full refund.
    applyStimulus(8'd7, Z, 1'b0, 1'b1, 1'b0, SI, Z, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd7, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(Z, 8'd12, 1'b0, 1'b0, 1'b1, SC, 8'd10, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd60,  1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd110, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd160, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd210, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd255, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd50, Z, 1'b0, 1'b1, 1'b0, SC, 8'd255, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(Z, Z, 1'b1, 1'b0, 1'b0, SI, Z, 1'b0, 8'd20, 1'b1, 8'd255);

    // Reset mid-transaction with credit 25: outputs clear at once, no refund pulse.
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd10, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd10, Z, 1'b0, 1'b1, 1'b0, SC, 8'd20, 1'b0, 8'd20, 1'b0, Z);
    applyStimulus(8'd5,  Z, 1'b0, 1'b1, 1'b0, SC, 8'd25, 1'b0, 8'd20, 1'b0, Z);
    @(negedge clk);
    coin = Z; inputCoin = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    stepNo++;
    pushExpect(SI, Z, 1'b0, Z, 1'b0, Z);
    checkOutput();
    @(posedge clk);
    #1;
    stepNo++;
    pushExpect(SI, Z, 1'b0, Z, 1'b0, Z);
    checkOutput();
    resetN = 1'b1;
    applyStimulus(Z, Z, 1'b0, 1'b0, 1'b0, SI, Z, 1'b0, Z, 1'b0, Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
